parity_frame_serializer: RTL and testbench
==========================================

// Module: parity_frame_serializer
// PURPOSE
// - Upstream feeder for the serial parity checker: accepts parallel data words, appends one
//   parity bit per word and shifts the frame out one bit per cycle on data_out/valid_out.
// - data_out, valid_out and the sampled mode connect directly to the checker's data_in, valid
//   and mode inputs. Tie out_ready=1 in that hookup.
// - Has a one-word hold buffer, so consecutive frames go out with no idle cycle between them.
// PARAMETERS
// - DATA_W  7  data bits per word; frame length = DATA_W+1 bits (default 8-bit frame)
// PORTS
// - clk        in   1       system clock; all logic updates on its rising edge
// - reset      in   1       synchronous, active-low reset (0 = reset, sampled on clk rising edge)
// - in_data    in   DATA_W  parallel word to send
// - in_mode    in   1       parity mode for this word: 0 = even, 1 = odd
// - in_valid   in   1       in_data/in_mode valid
// - in_ready   out  1       block can accept a word; transfer occurs when in_valid && in_ready
// - data_out   out  1       serial bit, MSB of word first, parity bit last
// - valid_out  out  1       data_out is a valid frame bit
// - mode_out   out  1       mode of the frame in flight (drives checker mode)
// - out_ready  in   1       downstream accepts the bit; the bit advances when valid_out && out_ready
// - frame_done out  1       one-cycle pulse in the cycle the parity bit is accepted
// - busy       out  1       frame in flight or hold buffer occupied
// BEHAVIOUR
// - Reset (reset=0 at a clk edge) drives: data_out=0, valid_out=0, mode_out=0, frame_done=0,
//   busy=0; hold buffer is emptied; FSM goes to IDLE. in_ready=0 while reset=0, and 1 in the
//   first cycle after release.
// - Reset applied mid-frame aborts the frame and discards the hold buffer. No partial parity
//   bit is emitted.
// - Parity bit: mode 0 (even) => ^word; mode 1 (odd) => ~^word. Total ones in the frame are
//   then even or odd as selected.
// - Mode is captured with the word. A change on in_mode mid-frame has no effect on the frame
//   in flight.
// - in_ready = !hold_full (combinational, gated by reset).
// - Accept, IDLE, hold empty: the word loads the shifter. The first data bit is on data_out
//   with valid_out=1 in the next cycle (latency 1).
// - Accept, shifter busy: the word goes to the hold buffer.
// FSM states:
// - IDLE -> DATA on load.
// - DATA: bit index counts DATA_W-1..0, advancing only on out_ready. On the last data bit
//   accepted -> PAR.
// - PAR: drives the parity bit. When accepted, pulse frame_done, then:
//   - hold full: load the hold word into the shifter and go to DATA (next frame's MSB appears
//     the next cycle, no gap), clear hold, in_ready rises;
//   - else if in_valid in the same cycle: load directly;
//   - else go to IDLE with valid_out=0.
// - Stall: out_ready=0 holds data_out, valid_out, mode_out and the bit index stable.
// - Simultaneous accept-into-hold and hold-drain in the same cycle: the drain wins first, then
//   the new word is written into the now-free hold slot. Never lose or duplicate a word.
// - busy=1 from the cycle after the first accept until the cycle after the last frame_done
//   with hold empty.
// - Bit index width is $clog2(DATA_W+1). Use no wrap-around beyond DATA_W; a DATA_W of 1
//   must work.
// STRUCTURE
// - Package parity_pkg: MODE_EVEN=1'b0, MODE_ODD=1'b1, FSM state encoding
//   (IDLE/DATA/PAR, 2 bits).
// - Sub-module parity_gen (combinational): word + mode -> parity bit. Shared with the checker
//   so both sides agree.
// - Top level holds the FSM, shifter, hold buffer and handshake logic.
// TESTING
// - Word 7'b1101000, mode 0, out_ready=1 -> data_out 1,1,0,1,0,0,0,1 on 8 consecutive
//   cycles, starting 1 cycle after accept; frame_done on the 8th bit; the checker
//   downstream reports parity_ok=1.
// - Same word, mode 1 -> last bit 0; 7'b0000000 mode 0 -> parity 0, mode 1 -> parity 1.
// - Two words back-to-back (7'h55 then 7'h2A, in_valid held high) -> 16 contiguous valid
//   bits; in_ready=0 only while the hold buffer is full; no dropped or repeated word.
// - out_ready=0 for 3 cycles mid-frame (after bit 3) -> outputs frozen; the remaining bits
//   resume unchanged; frame_done is delayed by exactly 3 cycles.
// - reset=0 during bit 5 of a frame with hold full -> next cycle valid_out=0, busy=0; after
//   release in_ready=1 and a new word starts a clean frame.
// - Toggle in_mode every cycle during a frame -> parity bit still matches the mode sampled at
//   accept.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame serializer and its downstream checker.
package parity_pkg;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAR  = 2'd2
   } state_e;

endpackage

// File: rtl/parity_gen.sv
// Combinational parity bit generator shared by serializer and checker.
module parity_gen
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 7
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic              mode_i,
   output logic              parity_o
);

   // Even mode makes the frame's total ones even, odd mode makes it odd.
   always_comb begin
      parity_o = (mode_i == MODE_ODD) ? ~(^data_i) : (^data_i);
   end

endmodule

// File: rtl/parity_frame_serializer.sv
// Word-to-serial framer: MSB-first data bits followed by one parity bit,
// with a one-word hold buffer so frames can run back to back.
module parity_frame_serializer
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              data_out,
   output logic              valid_out,
   output logic              mode_out,
   input  logic              out_ready,
   output logic              frame_done,
   output logic              busy
);

   localparam int unsigned     IDXW    = $clog2(DATA_W + 1);
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(DATA_W - 1);

   state_e            state_q;
   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] sh_d;
   logic [IDXW-1:0]   idx_q;
   logic              par_q;
   logic              hold_full_q;
   logic [DATA_W-1:0] hold_data_q;
   logic              hold_mode_q;
   logic              data_out_q;
   logic              valid_out_q;
   logic              mode_out_q;
   logic              busy_q;

   logic [DATA_W-1:0] ld_data;
   logic              ld_mode;
   logic              ld_par;
   logic              accept;
   logic              adv;
   logic              direct;
   logic              load_en;
   logic              hold_wr;
   logic              hold_clr;

   // Parity is computed once, on whichever word is about to enter the shifter.
   parity_gen #(
      .DATA_W (DATA_W)
   ) u_parity_gen (
      .data_i   (ld_data),
      .mode_i   (ld_mode),
      .parity_o (ld_par)
   );

   // Handshake decode and load-source selection (hold buffer has priority).
   always_comb begin
      in_ready   = reset & ~hold_full_q;
      accept     = in_valid & in_ready;
      adv        = valid_out_q & out_ready;
      ld_data    = hold_full_q ? hold_data_q : in_data;
      ld_mode    = hold_full_q ? hold_mode_q : in_mode;
      sh_d       = sh_q << 1;
      // A word goes straight to the shifter when idle or when the parity bit
      // is leaving this cycle; otherwise it parks in the hold slot.
      direct     = (state_q == S_IDLE) | ((state_q == S_PAR) & adv);
      load_en    = ((state_q == S_IDLE) & accept)
                 | ((state_q == S_PAR) & adv & (hold_full_q | accept));
      hold_wr    = accept & ~direct;
      hold_clr   = (state_q == S_PAR) & adv & hold_full_q;
      frame_done = reset & (state_q == S_PAR) & out_ready;
      data_out   = data_out_q;
      valid_out  = valid_out_q;
      mode_out   = mode_out_q;
      busy       = busy_q;
   end

   // Framing FSM, shifter, hold buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sh_q        <= '0;
         idx_q       <= '0;
         par_q       <= 1'b0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         hold_mode_q <= 1'b0;
         data_out_q  <= 1'b0;
         valid_out_q <= 1'b0;
         mode_out_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (load_en) begin
            sh_q        <= ld_data;
            par_q       <= ld_par;
            mode_out_q  <= ld_mode;
            idx_q       <= IDX_TOP;
            data_out_q  <= ld_data[DATA_W-1];
            valid_out_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_DATA;
         end else begin
            case (state_q)
               S_DATA: begin
                  if (adv) begin
                     if (idx_q == '0) begin
                        data_out_q <= par_q;
                        state_q    <= S_PAR;
                     end else begin
                        sh_q       <= sh_d;
                        data_out_q <= sh_d[DATA_W-1];
                        idx_q      <= idx_q - IDXW'(1);
                     end
                  end
               end
               S_PAR: begin
                  if (adv) begin
                     valid_out_q <= 1'b0;
                     busy_q      <= 1'b0;
                     state_q     <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
         if (hold_clr) begin
            hold_full_q <= 1'b0;
         end
         if (hold_wr) begin
            hold_full_q <= 1'b1;
            hold_data_q <= in_data;
            hold_mode_q <= in_mode;
            busy_q      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Self-checking bench for parity_frame_serializer.
module tb_parity_frame_serializer;

   localparam int DW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_mode;
   logic          in_valid;
   logic          in_ready;
   logic          data_out;
   logic          valid_out;
   logic          mode_out;
   logic          out_ready;
   logic          frame_done;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   parity_frame_serializer #(
      .DATA_W (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .mode_out   (mode_out),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Expected frame, element [DW] is sent first, [0] is the parity bit.
   function automatic logic [DW:0] frame_bits(input logic [DW-1:0] w, input logic m);
      logic p;
      p = ((($countones(w) + int'(m)) % 2) == 1);
      return {w, p};
   endfunction

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", valid_out); end
      checks++; if (data_out !== 1'b0) begin failures++; $display("FAIL rst_data: got %b want 0", data_out); end
      checks++; if (mode_out !== 1'b0) begin failures++; $display("FAIL rst_mode: got %b want 0", mode_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", frame_done); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low: got %b want 0", in_ready); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rel: got %b want 1", in_ready); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid_rel: got %b want 0", valid_out); end
   endtask

   task automatic test_frame_basic();
      logic [DW-1:0] tw [4];
      logic          tm [4];
      logic          tp [4];
      logic [DW:0]   f;
      int            ones;
      tw[0] = 7'b1101000; tm[0] = 1'b0; tp[0] = 1'b1;
      tw[1] = 7'b1101000; tm[1] = 1'b1; tp[1] = 1'b0;
      tw[2] = 7'b0000000; tm[2] = 1'b0; tp[2] = 1'b0;
      tw[3] = 7'b0000000; tm[3] = 1'b1; tp[3] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         f = frame_bits(tw[n], tm[n]);
         ones = 0;
         in_data = tw[n]; in_mode = tm[n]; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready[%0d]: got %b want 1", n, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0; in_mode = ~tm[n];
         #1;
         checks++; if (mode_out !== tm[n]) begin failures++; $display("FAIL basic_mode[%0d]: got %b want %b", n, mode_out, tm[n]); end
         for (int i = 0; i <= DW; i++) begin
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d.%0d]: got %b want 1", n, i, valid_out); end
            checks++; if (data_out !== f[DW-i]) begin failures++; $display("FAIL basic_bit[%0d.%0d]: got %b want %b", n, i, data_out, f[DW-i]); end
            checks++; if (frame_done !== (i == DW)) begin failures++; $display("FAIL basic_done[%0d.%0d]: got %b want %b", n, i, frame_done, (i == DW)); end
            if (i == DW) begin
               checks++; if (data_out !== tp[n]) begin failures++; $display("FAIL basic_par[%0d]: got %b want %b", n, data_out, tp[n]); end
            end
            ones += int'(data_out);
            @(posedge clk); #2;
         end
         checks++; if ((ones % 2) != int'(tm[n])) begin failures++; $display("FAIL basic_parity_ok[%0d]: ones %0d mode %b", n, ones, tm[n]); end
         checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL basic_idle_valid[%0d]: got %b want 0", n, valid_out); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy[%0d]: got %b want 0", n, busy); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW:0] fa;
      logic [DW:0] fb;
      logic        eb;
      int          j;
      fa = frame_bits(7'h55, 1'b0);
      fb = frame_bits(7'h2A, 1'b0);
      in_data = 7'h55; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = 7'h2A;
      for (int k = 1; k <= 2 * (DW + 1); k++) begin
         #1;
         j  = (k <= DW + 1) ? (k - 1) : (k - 1 - (DW + 1));
         eb = (k <= DW + 1) ? fa[DW-j] : fb[DW-j];
         checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, valid_out); end
         checks++; if (data_out !== eb) begin failures++; $display("FAIL b2b_bit[%0d]: got %b want %b", k, data_out, eb); end
         checks++; if (in_ready !== !(k >= 2 && k <= DW + 1)) begin failures++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, in_ready, !(k >= 2 && k <= DW + 1)); end
         checks++; if (frame_done !== (k == DW + 1 || k == 2 * (DW + 1))) begin failures++; $display("FAIL b2b_done[%0d]: got %b", k, frame_done); end
         @(posedge clk); #1;
         if (k == 1) in_valid = 1'b0;
      end
      #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_end_valid: got %b want 0", valid_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_stall();
      logic [DW-1:0] w;
      logic          m;
      logic [DW:0]   f;
      int            pos;
      int            done_k;
      w = DW'($urandom()); m = 1'($urandom());
      f = frame_bits(w, m);
      in_data = w; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      pos = 0; done_k = -1;
      for (int k = 1; k < 40 && pos <= DW; k++) begin
         out_ready = !(k >= 4 && k <= 6);
         #1;
         checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", k, valid_out); end
         checks++; if (data_out !== f[DW-pos]) begin failures++; $display("FAIL stall_bit[%0d]: got %b want %b", k, data_out, f[DW-pos]); end
         checks++; if (mode_out !== m) begin failures++; $display("FAIL stall_mode[%0d]: got %b want %b", k, mode_out, m); end
         checks++; if (frame_done !== (out_ready && pos == DW)) begin failures++; $display("FAIL stall_done[%0d]: got %b", k, frame_done); end
         if (frame_done === 1'b1) done_k = k;
         if (out_ready) pos++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      checks++; if (done_k != DW + 1 + 3) begin failures++; $display("FAIL stall_done_cycle: got %0d want %0d", done_k, DW + 4); end
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_midframe();
      logic [DW:0] f1;
      logic [DW:0] f3;
      f1 = frame_bits(7'h33, 1'b1);
      f3 = frame_bits(7'h4E, 1'b0);
      in_data = 7'h33; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = 7'h11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (data_out !== f1[DW-5]) begin failures++; $display("FAIL rmid_bit5: got %b want %b", data_out, f1[DW-5]); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_holdfull: got %b want 0", in_ready); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", valid_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rmid_done: got %b want 0", frame_done); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready_low: got %b want 0", in_ready); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_rel: got %b want 1", in_ready); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmid_no_drain: got %b want 0", valid_out); end
      in_data = 7'h4E; in_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      for (int i = 0; i <= DW; i++) begin
         checks++; if (data_out !== f3[DW-i] || valid_out !== 1'b1) begin failures++; $display("FAIL rmid_clean[%0d]: got %b/%b want %b/1", i, data_out, valid_out, f3[DW-i]); end
         @(posedge clk); #2;
      end
      checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_end: got valid %b busy %b want 0 0", valid_out, busy); end
   endtask

   task automatic test_mode_toggle();
      logic [DW-1:0] w;
      logic          m;
      logic [DW:0]   f;
      w = DW'($urandom()); m = 1'b1;
      f = frame_bits(w, m);
      in_data = w; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i <= DW; i++) begin
         in_mode = ~in_mode;
         #1;
         checks++; if (mode_out !== m) begin failures++; $display("FAIL tog_mode[%0d]: got %b want %b", i, mode_out, m); end
         checks++; if (data_out !== f[DW-i]) begin failures++; $display("FAIL tog_bit[%0d]: got %b want %b", i, data_out, f[DW-i]); end
         @(posedge clk); #1;
      end
      in_mode = 1'b0;
   endtask

   typedef struct packed {
      logic b;
      logic last;
      logic m;
   } exp_t;

   task automatic test_random();
      exp_t        q [$];
      int          nfr;
      logic        acc;
      logic        pop;
      logic [DW:0] f;
      nfr = 0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         in_valid  = (cyc < 380) && ($urandom_range(0, 2) != 0);
         in_data   = DW'($urandom());
         in_mode   = 1'($urandom());
         out_ready = (cyc >= 380) || ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (in_ready !== (nfr < 2)) begin failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, (nfr < 2)); end
         checks++; if (valid_out !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, valid_out, (q.size() > 0)); end
         checks++; if (busy !== (nfr > 0)) begin failures++; $display("FAIL rnd_busy[%0d]: got %b want %b", cyc, busy, (nfr > 0)); end
         checks++; if (frame_done !== (out_ready && q.size() > 0 && q[0].last)) begin failures++; $display("FAIL rnd_done[%0d]: got %b", cyc, frame_done); end
         if (q.size() > 0) begin
            checks++; if (data_out !== q[0].b || mode_out !== q[0].m) begin failures++; $display("FAIL rnd_bit[%0d]: got %b/%b want %b/%b", cyc, data_out, mode_out, q[0].b, q[0].m); end
         end
         acc = in_valid && (nfr < 2);
         pop = out_ready && (q.size() > 0);
         @(posedge clk);
         if (pop) begin
            if (q[0].last) nfr--;
            void'(q.pop_front());
         end
         if (acc) begin
            f = frame_bits(in_data, in_mode);
            for (int i = 0; i <= DW; i++) q.push_back('{b: f[DW-i], last: (i == DW), m: in_mode});
            nfr++;
         end
         #1;
      end
      in_valid = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rnd_drain: got valid %b busy %b want 0 0", valid_out, busy); end
   endtask

   initial begin
      test_reset();
      test_frame_basic();
      test_back_to_back();
      test_stall();
      test_reset_midframe();
      test_mode_toggle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
